aes256_round_engine: RTL and testbench
======================================

# aes256_round_engine

Iterative AES-256 encryption datapath that consumes round keys produced by the key expansion block. It drives the 4-bit round-key address and reads the 128-bit round key combinationally, performing one AES round per clock. It sits downstream of key expansion and upstream of the top-level data interface: plaintext in, ciphertext out, with a start/done handshake.

## Interface
- No parameters; rounds fixed at 14 (AES-256).
- Clk  input  1  system clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- Start  input  1  begin encryption of data_in; sampled only in IDLE
- data_in  input  128  plaintext; column c = data_in[32c+31:32c], row 0 byte at [32c+31:32c+24]
- Key_Ready  input  1  key expansion ready flag (round keys 0..14 valid)
- Key_In  input  128  round key at Addr_Key, same column/byte layout as data_in, valid combinationally in same cycle
- Addr_Key  output  4  round-key index 0..14
- data_out  output  128  ciphertext, registered, same layout
- Done  output  1  one-cycle pulse when data_out updates
- Busy  output  1  high from accepted Start until Done cycle inclusive

## Operation
- States: IDLE, WAIT_KEY (only with AES_KEY_WAIT_EN), ROUND, DONE.
- IDLE: Addr_Key = 0. On Start: state_reg <= data_in ^ Key_In (initial AddRoundKey), rnd <= 1, go ROUND.
- ROUND: Addr_Key = rnd. state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), Key_In) for rnd 1..13; rnd 14 omits MixColumns. After rnd 14: data_out <= result, go DONE; else rnd <= rnd+1.
- DONE: Done = 1 for this single cycle, Busy = 1; unconditionally return to IDLE next edge.
- SubBytes uses 16 forward S-boxes (four 4-byte SubWord instances); MixColumns in GF(2^8), polynomial 0x11B.
- ShiftRows: row r rotated left by r columns (row r of column c taken from column (c+r) mod 4).
- Start while Busy: ignored, no queuing; data_in not resampled.
- Addr_Key never exceeds 14; values 15 never driven.
- data_out holds last ciphertext until next completion or reset.

## Timing
- Reset values: data_out = 0, Done = 0, Busy = 0, Addr_Key = 0, state IDLE, rnd = 0.
- Latency: Start sampled at edge N; rounds 1..14 on edges N+1..N+14; data_out valid and Done high after edge N+14 (cycle N+15). Throughput: one block per 16 cycles (Start may be reasserted in the cycle after Done).
- Rst mid-operation: abort next edge; all outputs to reset values; no Done for aborted block.
- Rst and Start same edge: Rst wins.
- Key_In is read combinationally; the key source updates its storage on the opposite clock edge, so Key_In must be stable at each rising edge.
- Key_Ready changes mid-operation are not monitored.

## Configuration
- AES_KEY_WAIT_EN defined: Start in IDLE with Key_Ready = 0 latches data_in and enters WAIT_KEY (Busy = 1, Addr_Key = 0). WAIT_KEY performs initial AddRoundKey and goes ROUND on the first edge with Key_Ready = 1; latency extends by the wait. Start with Key_Ready = 1 behaves as undefined-macro case.
- Undefined: Key_Ready ignored; WAIT_KEY absent; latency fixed at 15 cycles; integrator guarantees keys are ready before Start.

## Test plan
- FIPS-197 C.3: key 000102..1f via key-expansion model, data_in = ccddeeff_8899aabb_44556677_00112233, Start 1 cycle -> Done pulse exactly 15 cycles later, data_out = 4b496089_eafc4990_516745bf_8ea2b7ca, Busy high 15 cycles.
- Addr_Key sequence check: same run -> Addr_Key = 0 at Start edge, then 1,2,...,14 on successive cycles, 0 in DONE/IDLE.
- Start held high continuously -> blocks complete every 16 cycles, identical ciphertext, extra Starts while Busy ignored.
- Rst asserted at round 7 -> next cycle data_out = 0, Busy = 0, Done never pulses; fresh Start then yields correct ciphertext.
- AES_KEY_WAIT_EN: Start with Key_Ready = 0, raise Key_Ready 5 cycles later -> Done 20 cycles after Start, correct ciphertext; macro undefined, same stimulus -> Done at 15 cycles (result compared against model using keys present).
- Back-to-back with all-zero plaintext and all-zero key -> data_out = FIPS/NIST known answer dc95c078_a2408989_ad48a214_92842087 word-reversed to layout (model-checked).

Source files
------------

// File: rtl/aes256_round_engine.sv
// aes256_round_engine
// Iterative AES-256 encryption core. It performs one round per clock and
// fetches each round key combinationally from the key expansion block
// through Addr_Key/Key_In.
//
// Build option: define AES_KEY_WAIT_EN to add a WAIT_KEY state. In that
// state a Start seen while Key_Ready is low parks the plaintext until the
// round keys are ready. Without the macro, Key_Ready is ignored and the
// latency is fixed at 15 cycles from the Start edge to Done.
//
// Byte layout used on every 128-bit bus:
//   column c = bits [32c+31:32c]
//   row r of column c = bits [32c+31-8r -: 8]
module aes256_round_engine (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] data_in,
    input  logic         Key_Ready,
    input  logic [127:0] Key_In,
    output logic [3:0]   Addr_Key,
    output logic [127:0] data_out,
    output logic         Done,
    output logic         Busy
);

    // Forward S-box. Entry 0x00 is the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] LAST_ROUND = 4'd14;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROUND    = 2'd1,
`ifdef AES_KEY_WAIT_EN
        WAIT_KEY = 2'd3,
`endif
        DONE     = 2'd2
    } fsm_t;

    // One S-box lookup. Bit offset of entry x is 8*(255-x) = {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    // SubWord: substitute all four bytes of one column.
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MixColumns on one column: the circulant matrix [2 3 1 1].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        mix_column = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    endfunction

    fsm_t         fsm_reg;
    fsm_t         fsm_next;
    logic [127:0] state_reg;
    logic [127:0] state_next;
    logic [3:0]   rnd_reg;
    logic [3:0]   rnd_next;
    logic [127:0] data_out_reg;
    logic [127:0] data_out_next;
    logic [3:0]   addr_key;

    logic [127:0] sub_bytes;
    logic [127:0] shifted;
    logic [127:0] mixed;
    logic [127:0] round_out;

    genvar gi;

    // SubBytes: four SubWord instances, one per column.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub_word
            assign sub_bytes[32*gi +: 32] = sub_word(state_reg[32*gi +: 32]);
        end
    endgenerate

    // ShiftRows: row r of column c is taken from column (c+r) mod 4.
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift_rows
            localparam int COL = gi / 4;
            localparam int ROW = gi % 4;
            localparam int SRC = (COL + ROW) % 4;
            assign shifted[32*COL+31-8*ROW -: 8] = sub_bytes[32*SRC+31-8*ROW -: 8];
        end
    endgenerate

    // MixColumns on each column of the shifted state.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mix_columns
            assign mixed[32*gi +: 32] = mix_column(shifted[32*gi +: 32]);
        end
    endgenerate

    // The final round skips MixColumns. AddRoundKey uses the key selected by rnd_reg.
    assign round_out = ((rnd_reg == LAST_ROUND) ? shifted : mixed) ^ Key_In;

`ifndef AES_KEY_WAIT_EN
    // Key_Ready has no function in this build. The integrator only issues
    // Start after the round keys are valid.
    logic key_ready_unused;
    assign key_ready_unused = Key_Ready;
`endif

    // Next-state, datapath and key-address decode for the round sequencer.
    always_comb begin
        fsm_next      = fsm_reg;
        state_next    = state_reg;
        rnd_next      = rnd_reg;
        data_out_next = data_out_reg;
        addr_key      = 4'd0;
        case (fsm_reg)
            IDLE: begin
                if (Start) begin
`ifdef AES_KEY_WAIT_EN
                    if (!Key_Ready) begin
                        // Park the plaintext. Whitening happens after the keys are ready.
                        state_next = data_in;
                        fsm_next   = WAIT_KEY;
                    end else begin
                        state_next = data_in ^ Key_In;
                        rnd_next   = 4'd1;
                        fsm_next   = ROUND;
                    end
`else
                    state_next = data_in ^ Key_In;
                    rnd_next   = 4'd1;
                    fsm_next   = ROUND;
`endif
                end
            end
`ifdef AES_KEY_WAIT_EN
            WAIT_KEY: begin
                if (Key_Ready) begin
                    state_next = state_reg ^ Key_In;
                    rnd_next   = 4'd1;
                    fsm_next   = ROUND;
                end
            end
`endif
            ROUND: begin
                addr_key   = rnd_reg;
                state_next = round_out;
                if (rnd_reg == LAST_ROUND) begin
                    data_out_next = round_out;
                    fsm_next      = DONE;
                end else begin
                    rnd_next = rnd_reg + 4'd1;
                end
            end
            DONE: begin
                rnd_next = 4'd0;
                fsm_next = IDLE;
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // Register the sequencer state, the working block and the ciphertext.
    // The synchronous reset aborts any block in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            fsm_reg      <= IDLE;
            state_reg    <= 128'd0;
            rnd_reg      <= 4'd0;
            data_out_reg <= 128'd0;
        end else begin
            fsm_reg      <= fsm_next;
            state_reg    <= state_next;
            rnd_reg      <= rnd_next;
            data_out_reg <= data_out_next;
        end
    end

    assign Addr_Key = addr_key;
    assign data_out = data_out_reg;
    assign Done     = (fsm_reg == DONE);
    assign Busy     = (fsm_reg != IDLE);

endmodule

// File: tb/tb_aes256_round_engine.sv
// Directed testbench for aes256_round_engine. The bench has its own AES-256
// key expansion, built on an arithmetic S-box (GF inverse plus affine
// transform). It serves Key_In from that schedule and checks the results
// against FIPS-197 / NIST known-answer ciphertexts.
module tb_aes256_round_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] data_in;
    logic         key_ready;
    logic [127:0] key_in;
    logic [3:0]   addr_key;
    logic [127:0] data_out;
    logic         done;
    logic         busy;

    logic [127:0] rk [0:14];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] KEY_C3  = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [127:0] PT_C3   = 128'hccddeeff_8899aabb_44556677_00112233;
    localparam logic [127:0] CT_C3   = 128'h4b496089_eafc4990_516745bf_8ea2b7ca;
    localparam logic [127:0] CT_ZERO = 128'h92842087_ad48a214_a2408989_dc95c078;
`ifdef AES_KEY_WAIT_EN
    localparam int WAIT_LAT = 20;
`else
    localparam int WAIT_LAT = 15;
`endif

    aes256_round_engine dut (
        .Clk       (clk),
        .Rst       (rst),
        .Start     (start),
        .data_in   (data_in),
        .Key_Ready (key_ready),
        .Key_In    (key_in),
        .Addr_Key  (addr_key),
        .data_out  (data_out),
        .Done      (done),
        .Busy      (busy)
    );

    always #5 clk = ~clk;

    // Key source: combinational read of the round key at Addr_Key.
    always_comb begin
        key_in = 128'h0;
        if (addr_key <= 4'd14) key_in = rk[addr_key];
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        gmul = p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        sbox_m = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        sub_word_m = {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = sub_word_m(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) rk[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Driver: encrypt one block and report ciphertext, latency and Busy cycles.
    // kr_at = 0 keeps Key_Ready high. Otherwise Key_Ready rises kr_at cycles
    // after the Start edge. Finishes in IDLE.
    task automatic run_block(input logic [127:0] pt, input int kr_at,
                             output logic [127:0] ct, output int lat, output int busy_cnt);
        int cyc;
        cyc      = 0;
        lat      = -1;
        busy_cnt = 0;
        ct       = 128'h0;
        key_ready = (kr_at == 0);
        data_in   = pt;
        start     = 1'b1;
        while (lat < 0 && cyc < 40) begin
            tick;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (kr_at != 0 && cyc == kr_at) key_ready = 1'b1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = cyc;
                ct  = data_out;
            end
        end
        key_ready = 1'b1;
        tick;
        $display("block pt=%h ct=%h latency=%0d busy=%0d", pt, ct, lat, busy_cnt);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        data_in = PT_C3;
        key_ready = 1'b1;
        tick;
        tick;
        n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy (rst beats start): got %b expected 0", busy); end
        n_checks++; if (addr_key !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", addr_key); end
        rst = 1'b0;
        start = 1'b0;
        tick;
    endtask

    task automatic test_fips_c3;
        int cyc = 0;
        int lat = -1;
        int busy_cnt = 0;
        logic [3:0] exp_addr;
        expand_key(KEY_C3);
        key_ready = 1'b1;
        data_in = PT_C3;
        start = 1'b1;
        n_checks++; if (addr_key !== 4'd0) begin n_fail++; $display("FAIL c3_addr_at_start: got %0d expected 0", addr_key); end
        while (lat < 0 && cyc < 40) begin
            tick;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                data_in = ~PT_C3;
            end
            if (busy) busy_cnt++;
            exp_addr = (cyc <= 14) ? 4'(cyc) : 4'd0;
            n_checks++; if (addr_key !== exp_addr) begin n_fail++; $display("FAIL c3_addr_cycle%0d: got %0d expected %0d", cyc, addr_key, exp_addr); end
            if (done) lat = cyc;
        end
        n_checks++; if (lat != 15) begin n_fail++; $display("FAIL c3_latency: got %0d expected 15", lat); end
        n_checks++; if (data_out !== CT_C3) begin n_fail++; $display("FAIL c3_ciphertext: got %h expected %h", data_out, CT_C3); end
        n_checks++; if (busy_cnt != 15) begin n_fail++; $display("FAIL c3_busy_cycles: got %0d expected 15", busy_cnt); end
        $display("block pt=%h ct=%h latency=%0d busy=%0d", PT_C3, data_out, lat, busy_cnt);
        tick;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL c3_done_single_pulse: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL c3_idle_busy: got %b expected 0", busy); end
        n_checks++; if (data_out !== CT_C3) begin n_fail++; $display("FAIL c3_data_out_hold: got %h expected %h", data_out, CT_C3); end
    endtask

    task automatic test_back_to_back;
        int prev = 0;
        int n_done = 0;
        int guard = 0;
        key_ready = 1'b1;
        data_in = PT_C3;
        start = 1'b1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            tick;
            if (cyc == 3) data_in = 128'hdeadbeef_01234567_89abcdef_feedface;
            if (cyc == 11) data_in = PT_C3;
            if (done) begin
                n_done++;
                $display("block b2b#%0d ct=%h at cycle %0d", n_done, data_out, cyc);
                n_checks++; if (data_out !== CT_C3) begin n_fail++; $display("FAIL b2b_ciphertext#%0d: got %h expected %h", n_done, data_out, CT_C3); end
                if (prev > 0) begin
                    n_checks++; if (cyc - prev != 16) begin n_fail++; $display("FAIL b2b_period: got %0d expected 16", cyc - prev); end
                end
                prev = cyc;
            end
        end
        start = 1'b0;
        n_checks++; if (n_done != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", n_done); end
        while (busy && guard < 20) begin
            tick;
            guard++;
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        int done_cnt = 0;
        logic [127:0] ct;
        int lat;
        int bc;
        key_ready = 1'b1;
        data_in = PT_C3;
        start = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            tick;
            if (cyc == 1) start = 1'b0;
            if (done) done_cnt++;
        end
        n_checks++; if (addr_key !== 4'd7) begin n_fail++; $display("FAIL rstmid_addr_round7: got %0d expected 7", addr_key); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++; if (data_out !== 128'h0) begin n_fail++; $display("FAIL rstmid_data_out: got %h expected 0", data_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (addr_key !== 4'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0d expected 0", addr_key); end
        for (int i = 0; i < 20; i++) begin
            if (done) done_cnt++;
            tick;
        end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt); end
        run_block(PT_C3, 0, ct, lat, bc);
        n_checks++; if (ct !== CT_C3) begin n_fail++; $display("FAIL rstmid_fresh_ct: got %h expected %h", ct, CT_C3); end
        n_checks++; if (lat != 15) begin n_fail++; $display("FAIL rstmid_fresh_latency: got %0d expected 15", lat); end
    endtask

    task automatic test_key_wait;
        logic [127:0] ct;
        int lat;
        int bc;
        run_block(PT_C3, 5, ct, lat, bc);
        n_checks++; if (lat != WAIT_LAT) begin n_fail++; $display("FAIL keywait_latency: got %0d expected %0d", lat, WAIT_LAT); end
        n_checks++; if (ct !== CT_C3) begin n_fail++; $display("FAIL keywait_ciphertext: got %h expected %h", ct, CT_C3); end
        n_checks++; if (bc != WAIT_LAT) begin n_fail++; $display("FAIL keywait_busy_cycles: got %0d expected %0d", bc, WAIT_LAT); end
    endtask

    task automatic test_zero_key;
        logic [127:0] ct;
        int lat;
        int bc;
        expand_key(256'h0);
        for (int b = 0; b < 2; b++) begin
            run_block(128'h0, 0, ct, lat, bc);
            n_checks++; if (ct !== CT_ZERO) begin n_fail++; $display("FAIL zero_ciphertext#%0d: got %h expected %h", b, ct, CT_ZERO); end
            n_checks++; if (lat != 15) begin n_fail++; $display("FAIL zero_latency#%0d: got %0d expected 15", b, lat); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key_ready = 1'b1;
        data_in = 128'h0;
        expand_key(KEY_C3);
        test_reset;
        test_fips_c3;
        test_back_to_back;
        test_reset_mid;
        test_key_wait;
        test_zero_key;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
